// File: rtl/apple2_ram_loader.sv
// apple2_ram_loader
//
// Streams bytes into RAM (load) or reads RAM back and compares it against the
// stream (verify). Before any RAM access the requested window
// [base_addr, base_addr+length) is checked against RAM_TOP. A window that runs
// past RAM_TOP is reported as an error at base_addr and no RAM access is made.
//
// Ports
//   clk, rst             clock and synchronous active-high reset
//   start, mode          command pulse (taken only in IDLE); 0 = load, 1 = verify
//   base_addr, length    transfer window, captured with start
//   s_valid, s_data      incoming byte stream
//   s_ready              stream byte accepted this cycle (combinational)
//   ram_addr, ram_w_en,
//   ram_din              registered RAM request
//   ram_dout             RAM read data, valid the cycle after ram_addr is driven
//   busy, done           not-idle flag and one-cycle end-of-operation pulse
//   error, err_addr      sticky fault flag and address of the first fault
//   count                bytes processed in the current operation
module apple2_ram_loader #(
    parameter logic [15:0] RAM_TOP = 16'hC000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] base_addr,
    input  logic [15:0] length,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic [15:0] ram_addr,
    output logic        ram_w_en,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] err_addr,
    output logic [15:0] count
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_REQ,
        CMP,
        FIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] remain_q, remain_d;
    logic [15:0] count_q, count_d;
    logic        error_q, error_d;
    logic [15:0] err_addr_q, err_addr_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_din_q, ram_din_d;
    logic        ram_w_en_q, ram_w_en_d;

    // The window end is formed in 17 bits so that a window reaching past
    // 16'hFFFF is seen as out of range rather than wrapping to a small value.
    logic [16:0] rangeEnd;
    assign rangeEnd = {1'b0, base_addr} + {1'b0, length};

    // Next-state logic. ram_w_en defaults low so a write pulse only ever
    // follows a stream handshake in WRITE.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        remain_d   = remain_q;
        count_d    = count_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_w_en_d = 1'b0;
        s_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d      = base_addr;
                    remain_d   = length;
                    count_d    = 16'h0000;
                    error_d    = 1'b0;
                    err_addr_d = 16'h0000;
                    if (rangeEnd > {1'b0, RAM_TOP}) begin
                        error_d    = 1'b1;
                        err_addr_d = base_addr;
                        state_d    = FIN;
                    end else if (length == 16'h0000) begin
                        state_d = FIN;
                    end else if (mode) begin
                        state_d = RD_REQ;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    ram_addr_d = ptr_q;
                    ram_din_d  = s_data;
                    ram_w_en_d = 1'b1;
                    ptr_d      = ptr_q + 16'd1;
                    remain_d   = remain_q - 16'd1;
                    count_d    = count_q + 16'd1;
                    if (remain_q == 16'd1) begin
                        state_d = FIN;
                    end
                end
            end

            RD_REQ: begin
                ram_addr_d = ptr_q;
                state_d    = CMP;
            end

            // Only the first mismatch records its address; later ones are
            // counted but leave err_addr alone.
            CMP: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if ((ram_dout != s_data) && !error_q) begin
                        error_d    = 1'b1;
                        err_addr_d = ptr_q;
                    end
                    ptr_d    = ptr_q + 16'd1;
                    remain_d = remain_q - 16'd1;
                    count_d  = count_q + 16'd1;
                    state_d  = (remain_q == 16'd1) ? FIN : RD_REQ;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears every output-visible register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 16'h0000;
            remain_q   <= 16'h0000;
            count_q    <= 16'h0000;
            error_q    <= 1'b0;
            err_addr_q <= 16'h0000;
            ram_addr_q <= 16'h0000;
            ram_din_q  <= 8'h00;
            ram_w_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            remain_q   <= remain_d;
            count_q    <= count_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_w_en_q <= ram_w_en_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_w_en = ram_w_en_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FIN);
    assign error    = error_q;
    assign err_addr = err_addr_q;
    assign count    = count_q;

endmodule

// File: tb/tb_apple2_ram_loader.sv
// tb_apple2_ram_loader
//
// Bench for apple2_ram_loader. Holds a 64 KiB RAM model and an operation-level
// reference model of the loader, drives directed and random transfers, and
// compares every DUT output against the model once per clock.
module tb_apple2_ram_loader;

    localparam logic [15:0] TOP = 16'hC000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [15:0] ram_addr;
    logic        ram_w_en;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] err_addr;
    logic [15:0] count;

    logic [7:0]  mem [0:65535];

    assign ram_dout = mem[ram_addr];

    apple2_ram_loader #(.RAM_TOP(TOP)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .base_addr(base_addr), .length(length),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .ram_addr(ram_addr), .ram_w_en(ram_w_en), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy), .done(done), .error(error),
        .err_addr(err_addr), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: an operation is "active" while bytes remain, "fin" for
    // the single closing cycle. In verify mode each byte first needs an
    // address cycle (inCmp low) before it can be compared (inCmp high).
    bit          mActive, mFin, mMode, mInCmp, mWen, mErr;
    logic [15:0] mPtr, mRemain, mAddr, mCount, mErrAddr;
    logic [7:0]  mDin;

    int checkCount = 0;
    int passCount  = 0;
    int wenCount   = 0;
    int doneCount  = 0;
    int readyCount = 0;
    int doneWenCount = 0;

    logic [7:0] dirData [0:7];
    bit         useDir = 1'b0;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic modelReset();
        mActive = 0; mFin = 0; mMode = 0; mInCmp = 0; mWen = 0; mErr = 0;
        mPtr = 0; mRemain = 0; mAddr = 0; mCount = 0; mErrAddr = 0; mDin = 0;
    endtask

    // Compares the DUT against the model and commits any DUT write to RAM.
    task automatic checkOutput();
        chk("busy", 32'(busy), 32'(mActive | mFin));
        chk("done", 32'(done), 32'(mFin));
        chk("s_ready", 32'(s_ready), 32'(mActive && (!mMode || mInCmp)));
        chk("ram_w_en", 32'(ram_w_en), 32'(mWen));
        chk("error", 32'(error), 32'(mErr));
        chk("err_addr", 32'(err_addr), 32'(mErrAddr));
        chk("count", 32'(count), 32'(mCount));
        if (mWen) begin
            chk("wr_addr", 32'(ram_addr), 32'(mAddr));
            chk("wr_data", 32'(ram_din), 32'(mDin));
        end
        if (mActive && mMode && mInCmp) chk("rd_addr", 32'(ram_addr), 32'(mAddr));
        if (ram_w_en === 1'b1) begin
            mem[ram_addr] = ram_din;
            wenCount++;
        end
        if (done === 1'b1) doneCount++;
        if (done === 1'b1 && ram_w_en === 1'b1) doneWenCount++;
        if (s_ready === 1'b1) readyCount++;
    endtask

    // Advances the model by one clock using the inputs now being driven.
    task automatic modelUpdate();
        bit wenNext;
        wenNext = 0;
        if (rst) begin
            modelReset();
            return;
        end
        if (mFin) begin
            mFin = 0;
        end else if (!mActive) begin
            if (start) begin
                mCount = 0; mErr = 0; mErrAddr = 0;
                mPtr = base_addr; mRemain = length; mMode = mode; mInCmp = 0;
                if (int'(base_addr) + int'(length) > int'(TOP)) begin
                    mErr = 1; mErrAddr = base_addr; mFin = 1;
                end else if (length == 0) begin
                    mFin = 1;
                end else begin
                    mActive = 1;
                end
            end
        end else if (!mMode) begin
            if (s_valid) begin
                wenNext = 1; mAddr = mPtr; mDin = s_data;
                mPtr++; mRemain--; mCount++;
                if (mRemain == 0) begin mActive = 0; mFin = 1; end
            end
        end else begin
            if (!mInCmp) begin
                mAddr = mPtr; mInCmp = 1;
            end else if (s_valid) begin
                if (mem[mPtr] !== s_data && !mErr) begin
                    mErr = 1; mErrAddr = mPtr;
                end
                mPtr++; mRemain--; mCount++; mInCmp = 0;
                if (mRemain == 0) begin mActive = 0; mFin = 1; end
            end
        end
        mWen = wenNext;
    endtask

    task automatic applyStimulus(input bit iRst, input bit iStart, input bit iMode,
                                 input logic [15:0] iBase, input logic [15:0] iLen,
                                 input bit iValid, input logic [7:0] iData);
        @(negedge clk);
        checkOutput();
        rst = iRst; start = iStart; mode = iMode;
        base_addr = iBase; length = iLen; s_valid = iValid; s_data = iData;
        modelUpdate();
    endtask

    function automatic logic [7:0] nextByte(input int badPct);
        if (useDir) return dirData[mCount[2:0]];
        if (mMode) begin
            if (int'($urandom_range(99)) < badPct) return mem[mPtr] ^ 8'($urandom_range(1, 255));
            return mem[mPtr];
        end
        return 8'($urandom);
    endfunction

    // validPct < 0 selects s_valid toggling every other cycle.
    task automatic runOp(input bit oMode, input logic [15:0] oBase, input logic [15:0] oLen,
                         input int validPct, input int badPct, input int rstAt);
        applyStimulus(0, 1, oMode, oBase, oLen, 0, 8'h00);
        for (int c = 0; c < 600 && (mActive || mFin); c++) begin
            bit v;
            bit junk;
            v = (validPct < 0) ? bit'(c % 2) : (int'($urandom_range(99)) < validPct);
            junk = ($urandom_range(9) == 0);
            if (c == rstAt) applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 8'h00);
            else applyStimulus(0, junk, ~oMode, 16'($urandom), 16'($urandom_range(0, 8)), v, nextByte(badPct));
        end
        chk("op_ends", 32'(mActive | mFin), 32'd0);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 8'h00);
    endtask

    initial begin
        int w0, d0, r0, dw0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst = 1; start = 0; mode = 0; base_addr = 0; length = 0; s_valid = 0; s_data = 0;
        modelReset();
        @(negedge clk);
        applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 8'h00);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 8'h00);

        // Load 11,22,33,44 at 0800 with s_valid held high.
        useDir = 1;
        dirData[0] = 8'h11; dirData[1] = 8'h22; dirData[2] = 8'h33; dirData[3] = 8'h44;
        w0 = wenCount; dw0 = doneWenCount;
        runOp(0, 16'h0800, 16'd4, 100, 0, -1);
        chk("load_mem0", 32'(mem[16'h0800]), 32'h11);
        chk("load_mem1", 32'(mem[16'h0801]), 32'h22);
        chk("load_mem2", 32'(mem[16'h0802]), 32'h33);
        chk("load_mem3", 32'(mem[16'h0803]), 32'h44);
        chk("load_writes", 32'(wenCount - w0), 32'd4);
        chk("load_done_with_last_write", 32'(doneWenCount - dw0), 32'd1);
        chk("load_count", 32'(count), 32'd4);
        chk("load_error", 32'(error), 32'd0);

        // Verify against RAM holding 11,22,99,44.
        mem[16'h0802] = 8'h99;
        w0 = wenCount; d0 = doneCount;
        runOp(1, 16'h0800, 16'd4, 100, 0, -1);
        chk("verify_error", 32'(error), 32'd1);
        chk("verify_err_addr", 32'(err_addr), 32'h0802);
        chk("verify_count", 32'(count), 32'd4);
        chk("verify_no_write", 32'(wenCount - w0), 32'd0);
        chk("verify_done", 32'(doneCount - d0), 32'd1);
        useDir = 0;

        // Window crossing RAM_TOP by one byte.
        w0 = wenCount; r0 = readyCount;
        runOp(0, 16'hBFFE, 16'd3, 100, 0, -1);
        chk("range_error", 32'(error), 32'd1);
        chk("range_err_addr", 32'(err_addr), 32'hBFFE);
        chk("range_no_write", 32'(wenCount - w0), 32'd0);
        chk("range_no_ready", 32'(readyCount - r0), 32'd0);

        // Window ending exactly at RAM_TOP.
        useDir = 1; dirData[0] = 8'hAA; dirData[1] = 8'hBB;
        w0 = wenCount;
        runOp(0, 16'hBFFE, 16'd2, 100, 0, -1);
        chk("edge_mem0", 32'(mem[16'hBFFE]), 32'hAA);
        chk("edge_mem1", 32'(mem[16'hBFFF]), 32'hBB);
        chk("edge_error", 32'(error), 32'd0);
        chk("edge_writes", 32'(wenCount - w0), 32'd2);
        useDir = 0;

        // Backpressure: s_valid toggling.
        w0 = wenCount;
        runOp(0, 16'h1000, 16'd6, -1, 0, -1);
        chk("bp_writes", 32'(wenCount - w0), 32'd6);
        chk("bp_count", 32'(count), 32'd6);

        // Zero length.
        w0 = wenCount; d0 = doneCount;
        runOp(0, 16'h3000, 16'd0, 100, 0, -1);
        chk("zero_no_write", 32'(wenCount - w0), 32'd0);
        chk("zero_done", 32'(doneCount - d0), 32'd1);
        chk("zero_count", 32'(count), 32'd0);

        // Reset after two of eight bytes, with a start attempted while busy.
        useDir = 1; dirData[0] = 8'h5A; dirData[1] = 8'hA5;
        applyStimulus(0, 1, 0, 16'h2000, 16'd8, 0, 8'h00);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, nextByte(0));
        applyStimulus(0, 1, 1, 16'h0100, 16'd4, 1, nextByte(0));
        applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 8'h00);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 8'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wen", 32'(ram_w_en), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mem0", 32'(mem[16'h2000]), 32'h5A);
        chk("rst_mem1", 32'(mem[16'h2001]), 32'hA5);
        useDir = 0;
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 8'h00);

        // Random transfers.
        for (int op = 0; op < 60; op++) begin
            bit          rMode;
            logic [15:0] rBase, rLen;
            int          rRst;
            rMode = 1'($urandom);
            case ($urandom_range(2))
                0: rBase = 16'($urandom_range(0, int'(TOP) - 31));
                1: rBase = TOP - 16'($urandom_range(0, 30));
                default: rBase = 16'($urandom);
            endcase
            rLen = 16'($urandom_range(0, 24));
            if ($urandom_range(9) == 0) begin
                if (rBase < TOP) rLen = 16'(int'(TOP) - int'(rBase) + int'($urandom_range(1, 1000)));
                else rLen = 16'($urandom);
            end
            rRst = ($urandom_range(9) == 0) ? int'($urandom_range(1, 10)) : -1;
            runOp(rMode, rBase, rLen, int'($urandom_range(30, 100)), 20, rRst);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
